eeprom_loader: RTL and testbench

Boot-time program loader for the TMS1000/TMS1100 soft processor. On a start pulse it reads a program image from an external SPI serial EEPROM (25LC-family, READ command 0x03, 16-bit address) and writes it byte-by-byte into the CPU's instruction ROM through a one-cycle write strobe. It sits directly upstream of the CPU core and fills the ROM whose bytes the core fetches; the core's program-select path enters its EEPROM start state, waits for `done`, then begins fetching at chapter 0, page 0, pc 0. A trailing checksum byte validates the image.

---
 rtl/eeprom_loader.sv | 203 ++++++++++++++++++++
 tb/tb_eeprom_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/eeprom_loader.sv
// rtl/eeprom_loader.sv - boot loader copying an SPI EEPROM image into the CPU instruction ROM
module eeprom_loader #(
  parameter int ROM_DEPTH  = 2048,
  parameter int ADDR_WIDTH = 11,
  parameter int CLK_DIV    = 4
) (
  input  logic                  raw_clk,
  input  logic                  button_reset,
  input  logic                  start,
  output logic                  eeprom_cs,
  output logic                  eeprom_sck,
  output logic                  eeprom_mosi,
  input  logic                  eeprom_miso,
  output logic                  rom_we,
  output logic [ADDR_WIDTH-1:0] rom_waddr,
  output logic [7:0]            rom_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  checksum_ok
);

  // 24 command/address bits, then the image plus one trailing checksum byte
  localparam int TOTAL_BITS = 24 + 8 * (ROM_DEPTH + 1);
  localparam int BITW       = $clog2(TOTAL_BITS);
  localparam int BCW        = $clog2(ROM_DEPTH + 1);
  localparam int DIVW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(CLK_DIV - 1);
  localparam logic [BITW-1:0] LAST_CMD = BITW'(23);
  localparam logic [BITW-1:0] LAST_BIT = BITW'(TOTAL_BITS - 1);
  localparam logic [BCW-1:0]  DEPTH_C  = BCW'(ROM_DEPTH);

  typedef enum logic [2:0] {IDLE, CMD, READ, FINISH, DONE} state_t;

  state_t                state_q, state_d;
  logic [DIVW-1:0]       div_q, div_d;
  logic                  sck_q, sck_d;
  logic                  cs_q, cs_d;
  logic [23:0]           cmd_sr_q, cmd_sr_d;
  logic [BITW-1:0]       bit_q, bit_d;
  logic [2:0]            rbit_q, rbit_d;
  logic [7:0]            shift_q, shift_d;
  logic                  byte_done_q, byte_done_d;
  logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]            acc_q, acc_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_WIDTH-1:0] rom_waddr_q, rom_waddr_d;
  logic [7:0]            rom_wdata_q, rom_wdata_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ok_q, ok_d;

  logic go, shifting, tick, rise, fall;

  // start is only honoured while no transfer is running
  assign go       = start && (state_q == IDLE || state_q == DONE);
  assign shifting = (state_q == CMD) || (state_q == READ);
  assign tick     = (div_q == DIV_LAST);
  // rise is the edge that samples MISO, fall is the edge that advances MOSI
  assign rise     = shifting && tick && !sck_q;
  assign fall     = shifting && tick && sck_q;

  // state register
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) state_q <= IDLE;
    else               state_q <= state_d;
  end

  // next-state logic: phase changes happen on the SCK fall that ends a bit
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (go) state_d = CMD;
      CMD:        if (fall && bit_q == LAST_CMD) state_d = READ;
      READ:       if (fall && bit_q == LAST_BIT) state_d = FINISH;
      FINISH:     if (tick) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // output and datapath next values
  always_comb begin
    div_d       = div_q;
    sck_d       = sck_q;
    cs_d        = cs_q;
    cmd_sr_d    = cmd_sr_q;
    bit_d       = bit_q;
    rbit_d      = rbit_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    byte_cnt_d  = byte_cnt_q;
    acc_d       = acc_q;
    rom_we_d    = 1'b0;
    rom_waddr_d = rom_waddr_q;
    rom_wdata_d = rom_wdata_q;
    busy_d      = busy_q;
    done_d      = done_q;
    ok_d        = ok_q;

    if (go) begin
      cs_d       = 1'b0;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      ok_d       = 1'b0;
      acc_d      = 8'h00;
      byte_cnt_d = '0;
      div_d      = '0;
      sck_d      = 1'b0;
      cmd_sr_d   = 24'h030000;
      bit_d      = '0;
      rbit_d     = 3'd0;
      shift_d    = 8'h00;
    end

    if (shifting || state_q == FINISH) begin
      div_d = tick ? '0 : div_q + DIVW'(1);
    end

    if (rise || fall) begin
      sck_d = ~sck_q;
    end

    // MOSI is the top bit of the command shifter; it drains to zero during READ
    if (fall) begin
      cmd_sr_d = {cmd_sr_q[22:0], 1'b0};
      bit_d    = bit_q + BITW'(1);
    end

    if (rise && state_q == READ) begin
      shift_d     = {shift_q[6:0], eeprom_miso};
      rbit_d      = rbit_q + 3'd1;
      byte_done_d = (rbit_q == 3'd7);
    end

    // a completed byte is summed; all but the trailing checksum byte go to ROM
    if (byte_done_q) begin
      acc_d = acc_q + shift_q;
      if (byte_cnt_q != DEPTH_C) begin
        rom_we_d    = 1'b1;
        rom_waddr_d = ADDR_WIDTH'(byte_cnt_q);
        rom_wdata_d = shift_q;
        byte_cnt_d  = byte_cnt_q + BCW'(1);
      end
    end

    if (state_q == FINISH && tick) begin
      cs_d   = 1'b1;
      busy_d = 1'b0;
      done_d = 1'b1;
      ok_d   = (acc_q == 8'h00);
    end
  end

  // datapath and output registers
  always_ff @(posedge raw_clk or negedge button_reset) begin
    if (!button_reset) begin
      div_q       <= '0;
      sck_q       <= 1'b0;
      cs_q        <= 1'b1;
      cmd_sr_q    <= 24'h000000;
      bit_q       <= '0;
      rbit_q      <= 3'd0;
      shift_q     <= 8'h00;
      byte_done_q <= 1'b0;
      byte_cnt_q  <= '0;
      acc_q       <= 8'h00;
      rom_we_q    <= 1'b0;
      rom_waddr_q <= '0;
      rom_wdata_q <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ok_q        <= 1'b0;
    end else begin
      div_q       <= div_d;
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      cmd_sr_q    <= cmd_sr_d;
      bit_q       <= bit_d;
      rbit_q      <= rbit_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      byte_cnt_q  <= byte_cnt_d;
      acc_q       <= acc_d;
      rom_we_q    <= rom_we_d;
      rom_waddr_q <= rom_waddr_d;
      rom_wdata_q <= rom_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ok_q        <= ok_d;
    end
  end

  assign eeprom_cs   = cs_q;
  assign eeprom_sck  = sck_q;
  assign eeprom_mosi = cmd_sr_q[23];
  assign rom_we      = rom_we_q;
  assign rom_waddr   = rom_waddr_q;
  assign rom_wdata   = rom_wdata_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign checksum_ok = ok_q;

endmodule

// File: tb/tb_eeprom_loader.sv
// tb/tb_eeprom_loader.sv - directed bench for eeprom_loader with an SPI EEPROM model
module tb_eeprom_loader;
  localparam int RD = 4;
  localparam int AW = 2;
  localparam int CD = 2;
  localparam int NBITS = 24 + 8 * (RD + 1);

  logic          raw_clk = 1'b0;
  logic          button_reset = 1'b0;
  logic          start = 1'b0;
  logic          eeprom_cs, eeprom_sck, eeprom_mosi, eeprom_miso;
  logic          rom_we;
  logic [AW-1:0] rom_waddr;
  logic [7:0]    rom_wdata;
  logic          busy, done, checksum_ok;

  eeprom_loader #(.ROM_DEPTH(RD), .ADDR_WIDTH(AW), .CLK_DIV(CD)) dut (
    .raw_clk(raw_clk), .button_reset(button_reset), .start(start),
    .eeprom_cs(eeprom_cs), .eeprom_sck(eeprom_sck), .eeprom_mosi(eeprom_mosi),
    .eeprom_miso(eeprom_miso), .rom_we(rom_we), .rom_waddr(rom_waddr),
    .rom_wdata(rom_wdata), .busy(busy), .done(done), .checksum_ok(checksum_ok)
  );

  always #5 raw_clk = ~raw_clk;

  int cyc = 0;
  always @(posedge raw_clk) cyc <= cyc + 1;

  logic [7:0] img [0:RD];

  int vectors = 0;
  int errs = 0;

  // EEPROM model and monitors, evaluated away from the active edge
  logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_we = 1'b0, prev_done = 1'b0;
  int          bit_n = 0, run = 0, duty_err = 0, wide_err = 0;
  int          we_cnt = 0, done_rises = 0, t0 = 0, done_cyc = 0, d = 0;
  logic [23:0] cmd_cap = 24'h0;
  int          we_addr [$];
  int          we_data [$];
  int          we_cyc [$];

  always @(negedge raw_clk) begin
    if (eeprom_cs !== 1'b0) begin
      bit_n = 0;
      eeprom_miso = 1'b0;
      run = 0;
    end else begin
      if (prev_cs) begin
        t0 = cyc;
        run = 1;
      end else if (eeprom_sck == prev_sck) begin
        run++;
      end else begin
        if (run != CD) duty_err++;
        run = 1;
      end
      if (eeprom_sck && !prev_sck) begin
        bit_n++;
        if (bit_n <= 24) cmd_cap = {cmd_cap[22:0], eeprom_mosi};
        // corrupt MISO right after the rising edge: only the rise may sample it
        eeprom_miso = ~eeprom_miso;
      end else if (!eeprom_sck && prev_sck && bit_n >= 24 && bit_n < NBITS) begin
        d = bit_n - 24;
        eeprom_miso = img[d / 8][7 - (d % 8)];
      end
    end
    if (rom_we === 1'b1) begin
      we_cnt++;
      we_addr.push_back(int'(rom_waddr));
      we_data.push_back(int'(rom_wdata));
      we_cyc.push_back(cyc);
      if (prev_we) wide_err++;
    end
    if (done === 1'b1 && !prev_done) begin
      done_rises++;
      done_cyc = cyc;
    end
    prev_sck  = eeprom_sck;
    prev_cs   = (eeprom_cs !== 1'b0);
    prev_we   = (rom_we === 1'b1);
    prev_done = (done === 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_img(input logic [7:0] b0, b1, b2, b3, ck);
    img[0] = b0; img[1] = b1; img[2] = b2; img[3] = b3; img[4] = ck;
  endtask

  task automatic pulse_start();
    @(negedge raw_clk);
    start = 1'b1;
    @(negedge raw_clk);
    start = 1'b0;
  endtask

  // one full load; mid != 0 re-pulses start after the second strobe
  task automatic load_check(input string tag, input logic exp_ok, input int mid);
    int base, dr, de, dw, n;
    base = we_cnt; dr = done_rises; de = duty_err; dw = wide_err;
    pulse_start();
    chk({tag, " cs_low_at_t0"}, {31'd0, eeprom_cs}, 32'd0);
    chk({tag, " busy_at_t0"}, {31'd0, busy}, 32'd1);
    chk({tag, " done_low_at_t0"}, {31'd0, done}, 32'd0);
    if (mid != 0) begin
      for (n = 0; n < 400 && we_cnt < base + 2; n++) @(negedge raw_clk);
      @(negedge raw_clk);
      start = 1'b1;
      @(negedge raw_clk);
      start = 1'b0;
      chk({tag, " busy_after_restart"}, {31'd0, busy}, 32'd1);
    end
    for (n = 0; n < 400 && done !== 1'b1; n++) @(negedge raw_clk);
    chk({tag, " done_reached"}, {31'd0, done}, 32'd1);
    repeat (3) @(negedge raw_clk);
    chk({tag, " cmd_bits"}, {8'd0, cmd_cap}, 32'h00030000);
    chk({tag, " strobe_count"}, we_cnt - base, 32'd4);
    for (int i = 0; i < 4 && base + i < we_cnt; i++) begin
      chk($sformatf("%s addr%0d", tag, i), we_addr[base + i], i);
      chk($sformatf("%s data%0d", tag, i), we_data[base + i], {24'd0, img[i]});
      chk($sformatf("%s time%0d", tag, i), we_cyc[base + i] - t0, 127 + 32 * i);
    end
    chk({tag, " done_time"}, done_cyc - t0, 32'd258);
    chk({tag, " done_rises"}, done_rises - dr, 32'd1);
    chk({tag, " checksum_ok"}, {31'd0, checksum_ok}, {31'd0, exp_ok});
    chk({tag, " sck_duty"}, duty_err - de, 32'd0);
    chk({tag, " we_width"}, wide_err - dw, 32'd0);
    chk({tag, " idle_cs"}, {31'd0, eeprom_cs}, 32'd1);
    chk({tag, " idle_sck"}, {31'd0, eeprom_sck}, 32'd0);
    chk({tag, " idle_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, " idle_mosi"}, {31'd0, eeprom_mosi}, 32'd0);
  endtask

  initial begin
    int base, n;
    set_img(8'h12, 8'h34, 8'h56, 8'h78, 8'hEC);

    // reset values
    repeat (3) @(negedge raw_clk);
    chk("rst cs", {31'd0, eeprom_cs}, 32'd1);
    chk("rst sck", {31'd0, eeprom_sck}, 32'd0);
    chk("rst mosi", {31'd0, eeprom_mosi}, 32'd0);
    chk("rst we", {31'd0, rom_we}, 32'd0);
    chk("rst waddr", {30'd0, rom_waddr}, 32'd0);
    chk("rst wdata", {24'd0, rom_wdata}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst ok", {31'd0, checksum_ok}, 32'd0);
    button_reset = 1'b1;
    repeat (3) @(negedge raw_clk);
    chk("idle sck", {31'd0, eeprom_sck}, 32'd0);

    load_check("good", 1'b1, 0);

    set_img(8'h12, 8'h34, 8'h56, 8'h78, 8'hED);
    load_check("badck", 1'b0, 0);

    set_img(8'h12, 8'h34, 8'h56, 8'h78, 8'hEC);
    load_check("restart", 1'b1, 1);

    // reset while byte 1 is being shifted in
    base = we_cnt;
    pulse_start();
    for (n = 0; n < 400 && we_cnt < base + 1; n++) @(negedge raw_clk);
    repeat (6) @(negedge raw_clk);
    button_reset = 1'b0;
    #1;
    chk("midrst cs", {31'd0, eeprom_cs}, 32'd1);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    chk("midrst sck", {31'd0, eeprom_sck}, 32'd0);
    repeat (4) @(negedge raw_clk);
    button_reset = 1'b1;
    repeat (150) @(negedge raw_clk);
    chk("midrst no_more_we", we_cnt - base, 32'd1);
    load_check("after_rst", 1'b1, 0);

    // relaunch from DONE with an all-ones image
    set_img(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h04);
    load_check("ones", 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  // hard stop in case the sequence above never completes
  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, required completion before 200000 time units");
    $fatal(1, "timeout");
  end
endmodule
